// File: rtl/delay_prog.sv
// delay_prog: runtime-programmable delay line built on a ring buffer.
// Each accepted sample on `signal` reappears on `q` exactly N accepted samples
// later, where N = delay_sel (0 is treated as 1). in_valid acts as a clock
// enable. A change of requested delay costs one FLUSH cycle (busy=1) that
// drops the offered sample and restarts the fill.
//
// Ports:
//   clk        clock, all state updates on posedge
//   reset_n    asynchronous active-low reset
//   signal     sample in (WIDTH)
//   in_valid   sample-accept enable
//   delay_sel  requested delay N (DEPTH_LOG2 bits, 0 means 1)
//   q          delayed sample, 0 while q_valid=0
//   q_valid    q holds a genuine delayed sample
//   busy       high during the single FLUSH cycle
module delay_prog #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [WIDTH-1:0]      signal,
  input  logic                  in_valid,
  input  logic [DEPTH_LOG2-1:0] delay_sel,
  output logic [WIDTH-1:0]      q,
  output logic                  q_valid,
  output logic                  busy
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {StFill, StRun, StFlush} state_e;

  state_e state_q, state_d;

  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] fill_q, fill_d;
  logic [DEPTH_LOG2-1:0] active_n_q, active_n_d;
  logic [DEPTH_LOG2-1:0] req_n;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [WIDTH-1:0]      q_q, q_d;
  logic                  q_valid_q, q_valid_d;
  logic                  change;
  logic                  accept;
  logic                  full;

  logic [WIDTH-1:0] mem [DEPTH];

  assign req_n  = (delay_sel == '0) ? DEPTH_LOG2'(1) : delay_sel;
  // A delay change outranks the accept: the sample offered that edge is dropped.
  assign change = (state_q != StFlush) && (req_n != active_n_q);
  assign accept = in_valid && (state_q != StFlush) && !change;
  assign full   = (fill_q == active_n_q);
  // Modulo-depth subtraction handles the pointer wrap with no special case.
  assign rd_ptr = wr_ptr_q - active_n_q;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StFill;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFill: begin
        if (change) begin
          state_d = StFlush;
        end else if (accept && (fill_d == active_n_q)) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (change) begin
          state_d = StFlush;
        end
      end
      StFlush: state_d = StFill;
      default: state_d = StFill;
    endcase
  end

  // Output logic
  always_comb begin
    busy    = (state_q == StFlush);
    q       = q_q;
    q_valid = q_valid_q;
  end

  // Datapath next-state
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    fill_d     = fill_q;
    active_n_d = active_n_q;
    q_d        = q_q;
    q_valid_d  = q_valid_q;
    if (change) begin
      active_n_d = req_n;
      fill_d     = '0;
      q_d        = '0;
      q_valid_d  = 1'b0;
    end else if (accept) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      if (full) begin
        // Read happens on the same edge as the write, so it sees the old entry.
        q_d       = mem[rd_ptr];
        q_valid_d = 1'b1;
      end else begin
        fill_d    = fill_q + 1'b1;
        q_d       = '0;
        q_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      fill_q     <= '0;
      active_n_q <= DEPTH_LOG2'(1);
      q_q        <= '0;
      q_valid_q  <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      fill_q     <= fill_d;
      active_n_q <= active_n_d;
      q_q        <= q_d;
      q_valid_q  <= q_valid_d;
    end
  end

  // Buffer contents are never observable before being written, so no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_ptr_q] <= signal;
    end
  end

endmodule

// File: tb/tb_delay_prog.sv
module tb_delay_prog;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] signal = '0;
  logic       in_valid = 1'b0;
  logic [3:0] delay_sel = 4'd1;
  logic [7:0] q;
  logic       q_valid;
  logic       busy;

  int n_checks = 0;
  int n_fail = 0;
  int step_no = 0;

  typedef struct {
    int         tag;
    logic       v;
    logic [7:0] q;
    logic       b;
  } exp_t;

  exp_t sb[$];

  delay_prog #(
    .WIDTH      (8),
    .DEPTH_LOG2 (4)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .signal    (signal),
    .in_valid  (in_valid),
    .delay_sel (delay_sel),
    .q         (q),
    .q_valid   (q_valid),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: one expectation per driven edge, compared on the following negedge.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk($sformatf("step%0d q_valid", e.tag), 32'(q_valid), 32'(e.v));
      chk($sformatf("step%0d q", e.tag), 32'(q), 32'(e.q));
      chk($sformatf("step%0d busy", e.tag), 32'(busy), 32'(e.b));
    end
  end

  // Drive one clock edge and queue the hand-derived response for it.
  task automatic step(input logic [7:0] s, input logic v, input logic [3:0] sel,
                      input logic ev, input logic [7:0] eq, input logic eb);
    exp_t e;
    signal    = s;
    in_valid  = v;
    delay_sel = sel;
    step_no++;
    e.tag = step_no;
    e.v   = ev;
    e.q   = eq;
    e.b   = eb;
    sb.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic mid_reset(input string name, input logic [3:0] sel);
    @(negedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    chk({name, " q async"}, 32'(q), 32'h0);
    chk({name, " q_valid async"}, 32'(q_valid), 32'h0);
    chk({name, " busy async"}, 32'(busy), 32'h0);
    @(posedge clk);
    @(negedge clk);
    #2;
    delay_sel = sel;
    reset_n   = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    repeat (2) @(posedge clk);
    #2;
    chk("reset q", 32'(q), 32'h0);
    chk("reset q_valid", 32'(q_valid), 32'h0);
    chk("reset busy", 32'(busy), 32'h0);
    @(negedge clk);
    #2;
    delay_sel = 4'd1;
    reset_n   = 1'b1;

    // N=1 from reset: no flush, first valid on 2nd accept
    for (int k = 1; k <= 8; k++) begin
      step(8'(k), 1'b1, 4'd1, k >= 2, (k >= 2) ? 8'(k - 1) : 8'h00, 1'b0);
    end

    // Reset mid-RUN, recover with N=5: flush on first clock
    mid_reset("rst1", 4'd5);
    step(8'hA0, 1'b1, 4'd5, 1'b0, 8'h00, 1'b1);
    step(8'hA1, 1'b1, 4'd5, 1'b0, 8'h00, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      step(8'hB0 + 8'(k), 1'b1, 4'd5, k >= 6, (k >= 6) ? 8'hB0 + 8'(k - 5) : 8'h00, 1'b0);
    end

    // N=5 with in_valid stalls: output frozen, no skip or duplicate
    step(8'h10, 1'b1, 4'd5, 1'b1, 8'hB4, 1'b0);
    step(8'hEE, 1'b0, 4'd5, 1'b1, 8'hB4, 1'b0);
    step(8'hEF, 1'b0, 4'd5, 1'b1, 8'hB4, 1'b0);
    step(8'h11, 1'b1, 4'd5, 1'b1, 8'hB5, 1'b0);
    step(8'h12, 1'b1, 4'd5, 1'b1, 8'hB6, 1'b0);
    step(8'h13, 1'b1, 4'd5, 1'b1, 8'hB7, 1'b0);
    step(8'h14, 1'b1, 4'd5, 1'b1, 8'hB8, 1'b0);
    step(8'h15, 1'b1, 4'd5, 1'b1, 8'h10, 1'b0);
    step(8'h16, 1'b1, 4'd5, 1'b1, 8'h11, 1'b0);

    // Retune to N=3
    step(8'hEE, 1'b1, 4'd3, 1'b0, 8'h00, 1'b1);
    step(8'hEE, 1'b1, 4'd3, 1'b0, 8'h00, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      step(8'h2F + 8'(k), 1'b1, 4'd3, k >= 4, (k >= 4) ? 8'h30 + 8'(k - 4) : 8'h00, 1'b0);
    end

    // In RUN at N=3 switch to 7: flush drops sample, valid after 8 accepts
    step(8'h99, 1'b1, 4'd7, 1'b0, 8'h00, 1'b1);
    step(8'h9A, 1'b1, 4'd7, 1'b0, 8'h00, 1'b0);
    for (int k = 1; k <= 9; k++) begin
      step(8'h6F + 8'(k), 1'b1, 4'd7, k >= 8, (k >= 8) ? 8'h70 + 8'(k - 8) : 8'h00, 1'b0);
    end

    // delay_sel=0 behaves as N=1
    step(8'hEE, 1'b1, 4'd0, 1'b0, 8'h00, 1'b1);
    step(8'hEE, 1'b1, 4'd0, 1'b0, 8'h00, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      step(8'(k), 1'b1, 4'd0, k >= 2, (k >= 2) ? 8'(k - 1) : 8'h00, 1'b0);
    end

    // delay_sel changes during FLUSH: second flush follows
    step(8'hEE, 1'b1, 4'd2, 1'b0, 8'h00, 1'b1);
    step(8'hEE, 1'b1, 4'd4, 1'b0, 8'h00, 1'b0);
    step(8'hEE, 1'b1, 4'd4, 1'b0, 8'h00, 1'b1);
    step(8'hEE, 1'b1, 4'd4, 1'b0, 8'h00, 1'b0);
    for (int k = 1; k <= 6; k++) begin
      step(8'h3F + 8'(k), 1'b1, 4'd4, k >= 5, (k >= 5) ? 8'h40 + 8'(k - 5) : 8'h00, 1'b0);
    end

    // Maximum delay N=15 over a 40-sample ramp, crossing pointer wraps
    step(8'hEE, 1'b1, 4'd15, 1'b0, 8'h00, 1'b1);
    step(8'hEE, 1'b1, 4'd15, 1'b0, 8'h00, 1'b0);
    for (int k = 1; k <= 40; k++) begin
      step(8'(k), 1'b1, 4'd15, k >= 16, (k >= 16) ? 8'(k - 15) : 8'h00, 1'b0);
    end

    // Reset mid-RUN with delay_sel=15 held: flush on first clock after release
    mid_reset("rst2", 4'd15);
    step(8'h55, 1'b1, 4'd15, 1'b0, 8'h00, 1'b1);
    step(8'h56, 1'b1, 4'd15, 1'b0, 8'h00, 1'b0);
    step(8'h57, 1'b1, 4'd15, 1'b0, 8'h00, 1'b0);

    repeat (2) @(negedge clk);
    #1;
    chk("scoreboard drained", 32'(sb.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
